// File: rtl/smag_mul.sv
// rtl/smag_mul.sv - sequential shift-add sign-magnitude fixed-point multiplier
module smag_mul #(
    parameter int BIT_DEPTH = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_DEPTH-1:0] a,
    input  logic [BIT_DEPTH-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_DEPTH-1:0] product,
    output logic                 overflow
);

    localparam int MW    = BIT_DEPTH - 1;
    localparam int ACC_W = 2 * MW;
    localparam int CW    = $clog2(MW);
    localparam logic [CW-1:0] LAST_CNT = CW'(MW - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [MW-1:0]        mcand_q, mcand_d;
    logic [MW-1:0]        mlt_q, mlt_d;
    logic                 sign_q, sign_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BIT_DEPTH-1:0] product_q, product_d;
    logic                 overflow_q, overflow_d;

    logic [ACC_W-1:0]     addend;
    logic [ACC_W-1:0]     acc_sum;
    logic                 sat;
    logic [MW-1:0]        mag;
    logic [BIT_DEPTH-1:0] final_prod;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;
    assign overflow  = overflow_q;

    // Next-state logic: accept operands, one shift-add step per BUSY cycle,
    // finalise on the last step from the already-updated accumulator sum.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mlt_d      = mlt_q;
        sign_d     = sign_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        overflow_d = overflow_q;

        addend  = mlt_q[0] ? ({{MW{1'b0}}, mcand_q} << cnt_q) : '0;
        acc_sum = acc_q + addend;

        // Anything at or above FRAC_BITS+MW cannot fit in the magnitude field.
        sat        = |(acc_sum >> (FRAC_BITS + MW));
        mag        = sat ? {MW{1'b1}} : acc_sum[FRAC_BITS +: MW];
        // A zero magnitude always leaves as +0, whatever the operand signs.
        final_prod = (mag == '0) ? '0 : {sign_q, mag};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a[MW-1:0];
                    mlt_d   = b[MW-1:0];
                    sign_d  = a[BIT_DEPTH-1] ^ b[BIT_DEPTH-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_sum;
                mlt_d = mlt_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    product_d  = final_prod;
                    overflow_d = sat;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mlt_q      <= '0;
            sign_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mlt_q      <= mlt_d;
            sign_q     <= sign_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
